// File: rtl/x_stream_loader_pkg.sv
// Shared constants for the x_stream_loader frame player and its consumers.
// Default frame geometry plus the FSM state encodings.
package x_stream_loader_pkg;

    localparam int NUM_KEYS = 64;
    localparam int DATA_W   = 7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_START    = 3'd1;
    localparam state_t ST_STREAM   = 3'd2;
    localparam state_t ST_GAPW     = 3'd3;
    localparam state_t ST_WAIT_FIN = 3'd4;

endpackage

// File: rtl/x_stream_loader_if.sv
// Host/top_top side bundle of the loader: buffer write port, control and stimulus outputs.
interface x_stream_loader_if #(
    parameter int DATA_W = 7,
    parameter int AW     = 6
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              go;
    logic              finish;
    logic              start_in;
    logic              valid_input;
    logic [DATA_W-1:0] X_load;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, go, finish,
        input  start_in, valid_input, X_load, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, go, finish,
        output start_in, valid_input, X_load, busy, done
    );
endinterface

// File: rtl/x_stream_loader_key_buf.sv
// Frame key store: synchronous write, combinational read. Not reset, so contents
// survive an aborted frame.
module key_buf #(
    parameter int NUM_KEYS = x_stream_loader_pkg::NUM_KEYS,
    parameter int DATA_W   = x_stream_loader_pkg::DATA_W,
    parameter int AW       = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam logic [AW:0] NK = (AW+1)'(NUM_KEYS);

    logic [DATA_W-1:0] mem [NUM_KEYS];

    // Addresses past the last key are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < NK))
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/x_stream_loader.sv
// Frame player feeding top_top: start pulse, NUM_KEYS qualified keys (optionally gapped),
// then waits for finish and pulses done. Every output is a register that trails the FSM by one cycle.
module x_stream_loader #(
    parameter int NUM_KEYS = x_stream_loader_pkg::NUM_KEYS,
    parameter int DATA_W   = x_stream_loader_pkg::DATA_W,
    parameter int GAP      = 0,
    parameter int AW       = $clog2(NUM_KEYS)
) (
    input logic              clk,
    input logic              rst,
    x_stream_loader_if.slave bus
);
    import x_stream_loader_pkg::*;

    localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_KEYS - 1);

    state_t            state;
    logic [AW-1:0]     idx;
    logic [GW-1:0]     gap_cnt;
    logic              fin_hit;
    logic [DATA_W-1:0] key;
    logic              buf_we;

    logic              start_r, valid_r, busy_r, done_r;
    logic [DATA_W-1:0] xload_r;

    // Writes need both the FSM and the registered busy idle, so the buffer stays
    // frozen from the go edge until busy has visibly dropped.
    assign buf_we = bus.wr_en && (state == ST_IDLE) && !busy_r;

    key_buf #(.NUM_KEYS(NUM_KEYS), .DATA_W(DATA_W), .AW(AW)) u_key_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (idx),
        .rdata (key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            fin_hit <= 1'b0;
            start_r <= 1'b0;
            valid_r <= 1'b0;
            xload_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            start_r <= (state == ST_START);
            valid_r <= (state == ST_STREAM);
            busy_r  <= (state != ST_IDLE);
            done_r  <= fin_hit;
            fin_hit <= 1'b0;
            if (state == ST_STREAM)
                xload_r <= key;

            case (state)
                ST_IDLE: begin
                    idx     <= '0;
                    gap_cnt <= '0;
                    if (bus.go)
                        state <= ST_START;
                end
                ST_START:
                    state <= ST_STREAM;
                ST_STREAM: begin
                    if (idx == IDX_LAST) begin
                        state <= ST_WAIT_FIN;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= (GAP > 0) ? ST_GAPW : ST_STREAM;
                    end
                end
                ST_GAPW: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_WAIT_FIN: begin
                    if (bus.finish) begin
                        fin_hit <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_in    = start_r;
    assign bus.valid_input = valid_r;
    assign bus.X_load      = xload_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;

endmodule

// File: tb/tb_x_stream_loader.sv
// Directed bench for x_stream_loader: 64-key/no-gap, 64-key/GAP=2 and 48-key instances.
module tb_x_stream_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    x_stream_loader_if #(.DATA_W(7), .AW(6)) if0 ();
    x_stream_loader_if #(.DATA_W(7), .AW(6)) if2 ();
    x_stream_loader_if #(.DATA_W(7), .AW(6)) if48 ();

    x_stream_loader #(.NUM_KEYS(64), .DATA_W(7), .GAP(0)) u0  (.clk(clk), .rst(rst), .bus(if0));
    x_stream_loader #(.NUM_KEYS(64), .DATA_W(7), .GAP(2)) u2  (.clk(clk), .rst(rst), .bus(if2));
    x_stream_loader #(.NUM_KEYS(48), .DATA_W(7), .GAP(0)) u48 (.clk(clk), .rst(rst), .bus(if48));

    // Beat monitors, sampled on the falling edge.
    logic [6:0] q0[$], q2[$], q48[$];
    int         t0[$], t2[$];
    int         st_t[$], dn_t[$];
    int         done_cnt0 = 0;

    always @(negedge clk) begin
        if (if0.valid_input)  begin q0.push_back(if0.X_load); t0.push_back(cyc); end
        if (if2.valid_input)  begin q2.push_back(if2.X_load); t2.push_back(cyc); end
        if (if48.valid_input) q48.push_back(if48.X_load);
        if (if0.start_in) st_t.push_back(cyc);
        if (if0.done) begin dn_t.push_back(cyc); done_cnt0++; end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return q0.size();
            2:       return q2.size();
            default: return q48.size();
        endcase
    endfunction

    task automatic wait_beats(input int which, input int n, input int budget);
        for (int c = 0; c < budget && qsize(which) < n; c++) @(negedge clk);
        check($sformatf("beats reached inst%0d n=%0d", which, n), qsize(which) >= n, 1);
    endtask

    task automatic pulse_go(input int which);
        @(negedge clk);
        case (which) 0: if0.go = 1'b1; 2: if2.go = 1'b1; default: if48.go = 1'b1; endcase
        @(negedge clk);
        if0.go = 1'b0; if2.go = 1'b0; if48.go = 1'b0;
    endtask

    task automatic pulse_fin(input int which);
        case (which) 0: if0.finish = 1'b1; 2: if2.finish = 1'b1; default: if48.finish = 1'b1; endcase
        @(negedge clk);
        if0.finish = 1'b0; if2.finish = 1'b0; if48.finish = 1'b0;
    endtask

    function automatic logic [6:0] exp0(input int i, input bit top7f);
        return (top7f && i == 63) ? 7'h7F : 7'(i);
    endfunction

    typedef struct {
        logic       go, fin, wen;
        logic [5:0] waddr;
        logic [6:0] wdata;
        logic       e_start, e_valid;
        logic [6:0] e_x;
        logic       e_busy, e_done;
    } vec_t;

    function automatic vec_t mk(input logic go, fin, wen, input logic [5:0] wa, input logic [6:0] wd,
                                input logic es, ev, input logic [6:0] ex, input logic eb, ed);
        vec_t v;
        v.go = go; v.fin = fin; v.wen = wen; v.waddr = wa; v.wdata = wd;
        v.e_start = es; v.e_valid = ev; v.e_x = ex; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    vec_t vt[8];

    initial begin
        int errs, base;
        {if0.go, if0.finish, if0.wr_en, if0.wr_addr, if0.wr_data} = '0;
        {if2.go, if2.finish, if2.wr_en, if2.wr_addr, if2.wr_data} = '0;
        {if48.go, if48.finish, if48.wr_en, if48.wr_addr, if48.wr_data} = '0;

        // go at edge k: start after k+1, first key after k+2; go/write/finish mid-stream ignored
        vt[0] = mk(1, 0, 0, 0, 0,     0, 0, 7'd0, 0, 0);
        vt[1] = mk(0, 0, 0, 0, 0,     1, 0, 7'd0, 1, 0);
        vt[2] = mk(0, 0, 0, 0, 0,     0, 1, 7'd0, 1, 0);
        vt[3] = mk(1, 0, 0, 0, 0,     0, 1, 7'd1, 1, 0);
        vt[4] = mk(1, 1, 1, 5, 7'h7F, 0, 1, 7'd2, 1, 0);
        vt[5] = mk(0, 0, 0, 0, 0,     0, 1, 7'd3, 1, 0);
        vt[6] = mk(0, 0, 0, 0, 0,     0, 1, 7'd4, 1, 0);
        vt[7] = mk(0, 0, 0, 0, 0,     0, 1, 7'd5, 1, 0);

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset start_in", if0.start_in, 0);
        check("reset valid", if0.valid_input, 0);
        check("reset X_load", if0.X_load, 0);
        check("reset busy", if0.busy, 0);
        check("reset done", if0.done, 0);
        rst = 1'b0;

        // Load: buf[i]=i on 64-key instances, buf[i]=i+10 on the 48-key one (addr 48..63 incl. 50 dropped)
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if0.wr_en = 1'b1;  if0.wr_addr = 6'(i);  if0.wr_data = 7'(i);
            if2.wr_en = 1'b1;  if2.wr_addr = 6'(i);  if2.wr_data = 7'(i);
            if48.wr_en = 1'b1; if48.wr_addr = 6'(i); if48.wr_data = (i >= 48) ? 7'h7F : 7'(i + 10);
        end
        @(negedge clk);
        if0.wr_en = 1'b0; if2.wr_en = 1'b0; if48.wr_en = 1'b0;

        // Table-driven start of a frame on the GAP=0 instance
        q0.delete(); t0.delete(); st_t.delete();
        for (int v = 0; v < 8; v++) begin
            if0.go = vt[v].go; if0.finish = vt[v].fin; if0.wr_en = vt[v].wen;
            if0.wr_addr = vt[v].waddr; if0.wr_data = vt[v].wdata;
            @(negedge clk);
            check($sformatf("vec%0d start_in", v), if0.start_in, vt[v].e_start);
            check($sformatf("vec%0d valid", v), if0.valid_input, vt[v].e_valid);
            check($sformatf("vec%0d X_load", v), if0.X_load, vt[v].e_x);
            check($sformatf("vec%0d busy", v), if0.busy, vt[v].e_busy);
            check($sformatf("vec%0d done", v), if0.done, vt[v].e_done);
        end
        {if0.go, if0.finish, if0.wr_en} = '0;

        wait_beats(0, 64, 200);
        repeat (3) @(negedge clk);
        check("gap0 beat count", q0.size(), 64);
        check("gap0 waits for finish busy", if0.busy, 1);
        check("gap0 no early done", done_cnt0, 0);
        check("gap0 single start", st_t.size(), 1);
        errs = 0;
        for (int i = 0; i < 64 && i < q0.size(); i++) begin
            if (q0[i] !== exp0(i, 0)) errs++;
            if (t0[i] != t0[0] + i) errs++;
        end
        check("gap0 data/timing errs", errs, 0);

        pulse_fin(0);
        check("fin edge+0 done", if0.done, 0);
        check("fin edge+0 busy", if0.busy, 1);
        @(negedge clk);
        check("fin edge+1 done", if0.done, 1);
        check("fin edge+1 busy", if0.busy, 0);
        @(negedge clk);
        check("done is one cycle", if0.done, 0);

        // GAP=2: beats 3 apart, 190-cycle span
        pulse_go(2);
        wait_beats(2, 64, 400);
        errs = 0;
        for (int i = 0; i < 64 && i < q2.size(); i++) begin
            if (q2[i] !== 7'(i)) errs++;
            if (i > 0 && t2[i] - t2[i-1] != 3) errs++;
        end
        check("gap2 data/spacing errs", errs, 0);
        if (t2.size() >= 64) check("gap2 span", t2[63] - t2[0] + 1, 190);
        else                 check("gap2 span", t2.size(), 64);
        @(negedge clk);
        pulse_fin(2);

        // Mid-frame reset at beat 30, then replay from index 0
        repeat (3) @(negedge clk);
        q0.delete(); t0.delete();
        base = done_cnt0;
        pulse_go(0);
        wait_beats(0, 31, 100);
        #2 rst = 1'b1;
        #1;
        check("async rst start_in", if0.start_in, 0);
        check("async rst valid", if0.valid_input, 0);
        check("async rst X_load", if0.X_load, 0);
        check("async rst busy", if0.busy, 0);
        check("async rst done", if0.done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no done after abort", done_cnt0, base);
        check("idle after abort", if0.busy, 0);

        q0.delete(); t0.delete();
        pulse_go(0);
        wait_beats(0, 64, 200);
        errs = 0;
        for (int i = 0; i < 64 && i < q0.size(); i++) if (q0[i] !== exp0(i, 0)) errs++;
        check("replay after reset errs (buf5 kept)", errs, 0);
        pulse_fin(0);
        repeat (2) @(negedge clk);

        // Boundary data on beat 0 and 63
        @(negedge clk);
        if0.wr_en = 1'b1; if0.wr_addr = 6'd63; if0.wr_data = 7'h7F;
        @(negedge clk);
        if0.wr_addr = 6'd0; if0.wr_data = 7'h00;
        @(negedge clk);
        if0.wr_en = 1'b0;
        q0.delete(); t0.delete();
        pulse_go(0);
        wait_beats(0, 64, 200);
        if (q0.size() >= 64) begin
            check("boundary beat0", q0[0], 7'h00);
            check("boundary beat63", q0[63], 7'h7F);
        end else check("boundary beat count", q0.size(), 64);
        pulse_fin(0);

        // 48-key frame: exactly 48 beats, out-of-range writes did not disturb it
        q48.delete();
        pulse_go(48);
        wait_beats(48, 48, 150);
        repeat (4) @(negedge clk);
        check("n48 beat count", q48.size(), 48);
        check("n48 waits for finish", if48.busy, 1);
        errs = 0;
        for (int i = 0; i < 48 && i < q48.size(); i++) if (q48[i] !== 7'(i + 10)) errs++;
        check("n48 data errs", errs, 0);
        pulse_fin(48);

        // Back-to-back frames with go held high
        repeat (3) @(negedge clk);
        q0.delete(); t0.delete(); st_t.delete(); dn_t.delete();
        if0.go = 1'b1;
        wait_beats(0, 64, 200);
        @(negedge clk);
        pulse_fin(0);
        wait_beats(0, 128, 200);
        if0.go = 1'b0;
        pulse_fin(0);
        repeat (6) @(negedge clk);
        check("b2b start count", st_t.size(), 2);
        check("b2b done count", dn_t.size(), 2);
        if (st_t.size() >= 2 && dn_t.size() >= 1) check("b2b start after done", st_t[1] - dn_t[0], 1);
        errs = 0;
        for (int i = 0; i < 128 && i < q0.size(); i++) if (q0[i] !== exp0(i % 64, 1)) errs++;
        check("b2b data errs", errs, 0);
        check("b2b total beats", q0.size(), 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: sim time exceeded, expected completion");
        $fatal(1);
    end
endmodule
